// File: rtl/mips32_light_port.sv
// Memory-mapped traffic-light port: validates CPU-written state codes, drives lamps, enforces a dwell.
// Optional yellow blink is enabled by defining MIPS32_LIGHT_BLINK_EN.
module mips32_light_port #(
    parameter logic [31:0] PORT_ADDR    = 32'h0000_0100,
    parameter int          DWELL_CYCLES = 8,
    parameter int          BLINK_HALF   = 4
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    output logic        lamp_red,
    output logic        lamp_green,
    output logic        lamp_yellow,
    output logic [1:0]  cur_state,
    output logic        err_illegal,
    output logic [7:0]  trans_count
);

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } light_e;

    typedef enum logic {
        DW_READY = 1'b0,
        DW_HOLD  = 1'b1
    } dwell_e;

    localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);

    light_e     r_state;
    dwell_e     r_dwell;
    dwell_e     w_dwell_nxt;
    logic [7:0] r_dwell_cnt;
    logic [7:0] w_dwell_cnt_nxt;
    logic       r_wr_ready;
    logic       r_lamp_red;
    logic       r_lamp_green;
    logic       r_lamp_yellow;
    logic       r_err;
    logic [7:0] r_count;

    logic [1:0] w_code;
    logic [1:0] w_succ;
    logic       w_accept;
    logic       w_legal;
    logic       w_illegal;
    logic       w_unused;

    assign w_code   = wr_data[1:0];
    assign w_unused = ^wr_data[31:2];

    always_comb begin
        w_succ = 2'd0;
        case (r_state)
            ST_RED:   w_succ = 2'd1;
            ST_GREEN: w_succ = 2'd2;
            default:  w_succ = 2'd0;
        endcase
    end

    // wr_ready gates acceptance, so writes arriving mid-dwell are simply dropped.
    assign w_accept  = wr_en && r_wr_ready && (wr_addr == PORT_ADDR);
    assign w_legal   = w_accept && (w_code == w_succ);
    assign w_illegal = w_accept && (w_code != r_state) && (w_code != w_succ);

    // Dwell FSM: state register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell     <= DW_READY;
            r_dwell_cnt <= 8'd0;
            r_wr_ready  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_dwell     <= w_dwell_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_wr_ready  <= (w_dwell_nxt == DW_READY);
        end
    end

    // Dwell FSM: next state. Counter reaching 0 releases HOLD on that edge.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_dwell_nxt     = r_dwell;
        w_dwell_cnt_nxt = r_dwell_cnt;
        case (r_dwell)
            DW_READY: begin
                if (w_legal) begin
                    w_dwell_nxt     = DW_HOLD;
                    w_dwell_cnt_nxt = DWELL_LOAD;
                end
            end
            DW_HOLD: begin
                if (r_dwell_cnt == 8'd0) begin
                    w_dwell_nxt = DW_READY;
                end else begin
                    w_dwell_cnt_nxt = r_dwell_cnt - 8'd1;
                end
            end
            default: begin
                w_dwell_nxt     = DW_READY;
                w_dwell_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RED;
            r_lamp_red   <= 1'b1;
            r_lamp_green <= 1'b0;
            r_err        <= 1'b0;
            r_count      <= 8'd0;
        end else begin
            if (w_illegal) begin
                r_err <= 1'b1;
            end
            if (w_legal) begin
                r_state      <= light_e'(w_code);
                r_lamp_red   <= (w_code == 2'd0);
                r_lamp_green <= (w_code == 2'd1);
                r_count      <= r_count + 8'd1;
            end
        end
    end

`ifdef MIPS32_LIGHT_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF - 1);

    logic [7:0] r_blink_cnt;

    // Entering YELLOW restarts the blink with the lamp on; leaving forces it off.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_lamp_yellow <= 1'b0;
            r_blink_cnt   <= 8'd0;
        end else if (w_legal) begin
            r_lamp_yellow <= (w_code == 2'd2);
            r_blink_cnt   <= 8'd0;
        end else if (r_state == ST_YELLOW) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= 8'd0;
                r_lamp_yellow <= ~r_lamp_yellow;
            end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
            end
        end
    end
`else
    logic [7:0] w_unused_blink;
    assign w_unused_blink = 8'(BLINK_HALF);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_lamp_yellow <= 1'b0;
        end else if (w_legal) begin
            r_lamp_yellow <= (w_code == 2'd2);
        end
    end
`endif

    assign wr_ready    = r_wr_ready;
    assign lamp_red    = r_lamp_red;
    assign lamp_green  = r_lamp_green;
    assign lamp_yellow = r_lamp_yellow;
    assign cur_state   = r_state;
    assign err_illegal = r_err;
    assign trans_count = r_count;

endmodule
